// File: rtl/ifu_fetch_bus.sv
// Multicycle in-order instruction fetch: one read per instruction, valid/ready
// handoff to decode, then wait for writeback's next PC before fetching again.
module ifu_fetch_bus #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h80000000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] araddr,
  output logic            arvalid,
  input  logic            arready,
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      rresp,
  input  logic            rvalid,
  output logic            rready,
  output logic [XLEN-1:0] instF,
  output logic [XLEN-1:0] pcF,
  output logic [XLEN-1:0] snpcF,
  output logic            fetch_fault,
  output logic            m_valid,
  input  logic            m_ready,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_dnpc
);

  typedef enum logic [1:0] {
    S_AR      = 2'd0,
    S_R       = 2'd1,
    S_OUT     = 2'd2,
    S_WAIT_WB = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic            r_fault;
  logic            r_pend_valid;
  logic [XLEN-1:0] r_pend_pc;
  logic            w_misaligned;

  assign w_misaligned = (r_pc[1:0] != 2'b00);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_AR;
      r_pc         <= RESET_PC;
      r_inst       <= '0;
      r_fault      <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_AR: begin
          if (w_misaligned) begin
            r_inst  <= '0;
            r_fault <= 1'b1;
          end
        end
        S_R: begin
          if (rvalid) begin
            r_inst  <= rdata;
            r_fault <= (rresp != 2'b00);
          end
        end
        S_WAIT_WB: begin
          // A live pulse is newer than anything parked in pend_*.
          if (wb_valid)
            r_pc <= wb_dnpc;
          else if (r_pend_valid)
            r_pc <= r_pend_pc;
        end
        default: ;
      endcase

      // Retirements that arrive before we are waiting for them are parked,
      // including one coincident with the decode handoff.
      if (r_state != S_WAIT_WB) begin
        if (wb_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_pc    <= wb_dnpc;
        end
      end else if (wb_valid || r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_AR:      if (w_misaligned) w_state_next = S_OUT;
                 else if (arready) w_state_next = S_R;
      S_R:       if (rvalid) w_state_next = S_OUT;
      S_OUT:     if (m_ready) w_state_next = S_WAIT_WB;
      S_WAIT_WB: if (wb_valid || r_pend_valid) w_state_next = S_AR;
      default:   w_state_next = S_AR;
    endcase
  end

  // Output decode; handshake strobes are forced low while reset is held.
  always_comb begin
    arvalid     = ~rst & (r_state == S_AR) & ~w_misaligned;
    rready      = ~rst & (r_state == S_R);
    m_valid     = ~rst & (r_state == S_OUT);
    araddr      = r_pc;
    pcF         = r_pc;
    snpcF       = r_pc + XLEN'(4);
    instF       = r_inst;
    fetch_fault = r_fault;
  end

endmodule

// File: tb/tb_ifu_fetch_bus.sv
// Directed bench for ifu_fetch_bus: hand-computed expectations checked with
// immediate assertions at each step.
module tb_ifu_fetch_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] instF;
  logic [31:0] pcF;
  logic [31:0] snpcF;
  logic        fetch_fault;
  logic        m_valid;
  logic        m_ready;
  logic        wb_valid;
  logic [31:0] wb_dnpc;

  int n_total = 0;
  int n_pass  = 0;
  int n_ar_hs = 0;
  int n_m_hs  = 0;
  int ar_base;
  int m_base;

  ifu_fetch_bus #(.XLEN(32), .RESET_PC(32'h80000000)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .instF(instF), .pcF(pcF), .snpcF(snpcF), .fetch_fault(fetch_fault),
    .m_valid(m_valid), .m_ready(m_ready),
    .wb_valid(wb_valid), .wb_dnpc(wb_dnpc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (arvalid && arready) n_ar_hs <= n_ar_hs + 1;
    if (m_valid && m_ready) n_m_hs <= n_m_hs + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    m_ready = 1'b0; wb_valid = 1'b0; wb_dnpc = '0;
    tick();
    tick();
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_pc", pcF, 32'h80000000);

    // 1: zero-wait fetch of the reset PC
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h00000013; m_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("t1_arvalid", arvalid, 1);
    check("t1_araddr", araddr, 32'h80000000);
    tick();
    check("t1_rready", rready, 1);
    check("t1_no_ar_in_r", arvalid, 0);
    tick();
    check("t1_mvalid", m_valid, 1);
    check("t1_inst", instF, 32'h00000013);
    check("t1_pc", pcF, 32'h80000000);
    check("t1_snpc", snpcF, 32'h80000004);
    check("t1_fault", fetch_fault, 0);
    arready = 1'b0; rvalid = 1'b0;
    tick();
    check("t1_wait_mvalid", m_valid, 0);
    check("t1_wait_arvalid", arvalid, 0);

    // 3a: retirement while waiting redirects the next fetch
    wb_valid = 1'b1; wb_dnpc = 32'h80000100;
    tick();
    wb_valid = 1'b0;
    check("t3_arvalid", arvalid, 1);
    check("t3_araddr", araddr, 32'h80000100);

    // 2: AR back-pressure, then decode back-pressure
    ar_base = n_ar_hs;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_arvalid_hold", arvalid, 1);
      check("t2_araddr_hold", araddr, 32'h80000100);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("t2_ar_once", n_ar_hs - ar_base, 1);
    check("t2_rready", rready, 1);
    rvalid = 1'b1; rdata = 32'h00100073; m_ready = 1'b0;
    tick();
    rvalid = 1'b0;
    m_base = n_m_hs;
    for (int i = 0; i < 5; i++) begin
      check("t2_mvalid_hold", m_valid, 1);
      check("t2_inst_hold", instF, 32'h00100073);
      check("t2_pc_hold", pcF, 32'h80000100);
      tick();
    end
    check("t2_no_ar_extra", n_ar_hs - ar_base, 1);

    // 3b: retirement coincident with the handoff must not be lost
    m_ready = 1'b1; wb_valid = 1'b1; wb_dnpc = 32'h80000100;
    tick();
    wb_valid = 1'b0;
    check("t2_single_handoff", n_m_hs - m_base, 1);
    check("t3b_wait_mvalid", m_valid, 0);
    tick();
    check("t3b_arvalid", arvalid, 1);
    check("t3b_araddr", araddr, 32'h80000100);

    // 4: bus error response
    arready = 1'b1; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b10;
    tick();
    tick();
    check("t4_mvalid", m_valid, 1);
    check("t4_fault", fetch_fault, 1);
    check("t4_inst", instF, 32'hDEADBEEF);
    tick();
    rresp = 2'b00;

    // 5: misaligned next PC, no bus access
    ar_base = n_ar_hs;
    wb_valid = 1'b1; wb_dnpc = 32'h80000102;
    tick();
    wb_valid = 1'b0;
    check("t5_no_arvalid", arvalid, 0);
    check("t5_pc", pcF, 32'h80000102);
    tick();
    check("t5_mvalid", m_valid, 1);
    check("t5_inst", instF, 0);
    check("t5_fault", fetch_fault, 1);
    check("t5_pc_out", pcF, 32'h80000102);
    check("t5_snpc", snpcF, 32'h80000106);
    check("t5_no_ar_hs", n_ar_hs - ar_base, 0);
    tick();

    // snpc wraps at the top of the address space
    wb_valid = 1'b1; wb_dnpc = 32'hFFFFFFFC;
    tick();
    wb_valid = 1'b0;
    check("wrap_snpc", snpcF, 32'h00000000);
    tick();
    check("t6_in_r", rready, 1);

    // 6: reset mid-read, then a stale rvalid must be ignored
    rst = 1'b1;
    #1;
    check("t6_rst_arvalid", arvalid, 0);
    check("t6_rst_rready", rready, 0);
    check("t6_rst_mvalid", m_valid, 0);
    tick();
    rst = 1'b0; arready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("t6_arvalid", arvalid, 1);
      check("t6_araddr", araddr, 32'h80000000);
      check("t6_stale_rready", rready, 0);
      tick();
    end
    arready = 1'b1; rvalid = 1'b0;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h00000013;
    tick();
    rvalid = 1'b0;
    check("t6_mvalid", m_valid, 1);
    check("t6_inst", instF, 32'h00000013);
    check("t6_pc", pcF, 32'h80000000);
    check("t6_fault", fetch_fault, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
